// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue sequencer for an external ALU.
// It accepts one instruction at a time and reads operands from an 8x8
// register file. It drives registered operands to the ALU for ALU_LAT cycles,
// then writes the result and/or flags back at the end of a one-cycle WB state.
module alu_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr_op,
  input  logic [2:0] instr_dst,
  input  logic [2:0] instr_src_a,
  input  logic [2:0] instr_src_b,
  input  logic       instr_imm_en,
  input  logic [7:0] instr_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] alu_sel,
  input  logic [7:0] alu_x,
  input  logic [7:0] alu_flags,
  output logic [7:0] flags_q,
  output logic       done,
  output logic       err,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [7:0] OP_DIV = 8'h04;
  localparam logic [7:0] OP_MOD = 8'h05;
  localparam logic [7:0] OP_CMP = 8'h0F;
  localparam logic [7:0] OP_MOV = 8'h80;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic [2:0] dst_q;
  logic [7:0] rf [8];
  logic [7:0] opnd_a, opnd_b;
  logic       accept, legal;

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign done        = (state == WB);
  assign dbg_data    = rf[dbg_addr];

  // Operand selection and legality of the offered instruction.
  always_comb begin
    opnd_a = rf[instr_src_a];
    opnd_b = rf[instr_src_b];
    legal  = 1'b0;
    if (instr_imm_en) opnd_b = instr_imm;
    // Load-immediate: MOV passes operand A, so the immediate goes there.
    if (instr_imm_en && instr_op == OP_MOV) opnd_a = instr_imm;
    if ((instr_op >= 8'h01 && instr_op <= 8'h0F) || instr_op == OP_MOV) legal = 1'b1;
    if ((instr_op == OP_DIV || instr_op == OP_MOD) && opnd_b == 8'h00) legal = 1'b0;
  end

  // Next-state logic: IDLE -> EXEC (ALU_LAT cycles) -> WB -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && legal) state_nxt = EXEC;
      EXEC:    if (cnt == 3'd1) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, latency counter, latched instruction and ALU drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      dst_q   <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= accept && !legal;
      case (state)
        IDLE: begin
          if (accept && legal) begin
            cnt     <= 3'(ALU_LAT);
            dst_q   <= instr_dst;
            alu_a   <= opnd_a;
            alu_b   <= opnd_b;
            alu_sel <= instr_op;
          end
        end
        EXEC: cnt <= cnt - 3'd1;
        WB: begin
          alu_a   <= '0;
          alu_b   <= '0;
          alu_sel <= '0;
        end
        default: ;
      endcase
    end
  end

  // Architectural writeback on the edge that leaves WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      flags_q <= '0;
    end else if (state == WB) begin
      if (alu_sel != OP_CMP) rf[dst_q] <= alu_x;
      if (alu_sel != OP_MOV) flags_q <= alu_flags;
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter ALU_LAT, default 1, meaning clock edges from the first edge at which operands are presented to the ALU until alu_x/alu_flags are valid; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr_ready  out  1  sequencer can accept; equals (state==IDLE).
REQ-006 instr_op  in  8  ALU selector code: 0x01..0x0F, or 0x80 for MOV.
REQ-007 instr_dst  in  3  destination register index.
REQ-008 instr_src_a  in  3  operand A register index.
REQ-009 instr_src_b  in  3  operand B register index.
REQ-010 instr_imm_en  in  1  use instr_imm instead of a register operand.
REQ-011 instr_imm  in  8  immediate value.
REQ-012 alu_a, alu_b, alu_sel  out  8 each  registered ALU operand and selector drive.
REQ-013 alu_x  in  8  ALU result.
REQ-014 alu_flags  in  8  ALU flags: [0] Z, [1] C, [2] S, [3] P, [6] O.
REQ-015 flags_q  out  8  architectural flags register.
REQ-016 done  out  1  high for exactly the WB cycle.
REQ-017 err  out  1  one-cycle pulse on a rejected instruction.
REQ-018 dbg_addr  in  3 / dbg_data  out  8  combinational register-file read port.

Function
REQ-019 The register file SHALL be 8 x 8-bit; flags_q SHALL be 8-bit.
REQ-020 FSM states SHALL be IDLE, EXEC, WB.
- Accept edge E0: instr_valid && instr_ready.
- On accept the FSM SHALL latch the instruction and load alu_a/alu_b/alu_sel.
- IDLE->EXEC on a legal accept.
REQ-021 Operand A SHALL be rf[src_a]. Operand B SHALL be rf[src_b], or instr_imm when instr_imm_en=1.
- Exception: op 0x80 with instr_imm_en=1 places instr_imm on alu_a (load-immediate).
REQ-022 EXEC SHALL last exactly ALU_LAT cycles, timed by a down-counter loaded with ALU_LAT at E0; EXEC->WB when the count expires.
REQ-023 alu_a/alu_b/alu_sel SHALL stay stable throughout EXEC and WB. In IDLE they SHALL be 0x00.
REQ-024 Writeback SHALL occur at the edge ending WB (WB->IDLE):
- Ops 0x01..0x0E: rf[dst]<=alu_x and flags_q<=alu_flags.
- Op 0x0F (CMP): flags_q only; register file unchanged.
- Op 0x80 (MOV): rf[dst] only; flags_q unchanged.
REQ-025 Latency SHALL be ALU_LAT+2 cycles from E0 to the first cycle with updated state. The next accept SHALL be possible in the first IDLE cycle.
REQ-026 A rejected instruction SHALL be accepted, pulse err in the cycle after E0, stay in IDLE, and make no writes. Rejection causes:
- op outside {0x01..0x0F, 0x80}
- op 0x04/0x05 with operand B == 0
REQ-027 Operands SHALL be read at E0. No hazard exists because writeback completes before the next accept; dst equal to a source is legal.
REQ-028 instr_valid outside IDLE SHALL be ignored.

Reset
REQ-029 When rst_n=0, asynchronously:
- state = IDLE; counter = 0
- all rf entries = 0x00; flags_q = 0x00
- alu_a, alu_b, alu_sel = 0x00
- done = 0, err = 0
REQ-030 Reset during EXEC or WB SHALL abort the instruction with no writeback. instr_ready SHALL be 1 in the first cycle after release.

Verification
REQ-031 Release reset -> dbg_data=0x00 for all 8 addresses, flags_q=0x00, instr_ready=1, alu_sel=0x00.
REQ-032 MOV imm 0x05->r1, MOV imm 0x03->r2, then ADD r3=r1+r2 with ALU_LAT=1 -> for the ADD, done high 2 cycles after E0; r3=0x08; flags_q[0]=0, flags_q[1]=0; flags_q unchanged by both MOVs.
REQ-033 r1=0xFF, ADD imm 0x01 -> r1 -> r1=0x00, flags_q[0]=1, flags_q[1]=1; r2=0x7F, ADD imm 0x01 -> r2 -> r2=0x80, flags_q[6]=1.
REQ-034 r1=0x05, CMP imm 0x05 -> flags_q=0x01, all registers unchanged; DIV r1 by imm 0x00 -> err pulse, no writes, instr_ready=1 next cycle; op 0x20 -> err.
REQ-035 ALU_LAT=3, SUB r4=0x09-imm 0x04 -> done exactly 4 cycles after E0, r4=0x05; back-to-back valid held high -> accepts every 5 cycles.
REQ-036 Assert rst_n=0 in the second EXEC cycle of REQ-035 -> r4 stays 0x00, done never asserts, instr_ready=1 after release.
